// File: rtl/seven_scan_decoder.sv
// Display-bus monitor: recovers hex digits from a multiplexed active-low 7-segment drive.
// Optional build macro SEVEN_ERR_COUNT_EN adds a saturating err_count output.
//
// state  | meaning
// IDLE   | no anode driven (s_an all ones)
// SETTLE | sample changed, waiting for it to hold still long enough to commit
// HOLD   | current sample committed; waiting for the next change
module seven_scan_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [6:0]                seg_in,
    input  logic [NUM_DIGITS-1:0]     an_in,
    output logic [4*NUM_DIGITS-1:0]   digit_val,
    output logic [NUM_DIGITS-1:0]     digit_valid,
    output logic [NUM_DIGITS-1:0]     digit_err,
    output logic                      an_conflict,
    output logic                      frame_done
`ifdef SEVEN_ERR_COUNT_EN
    ,
    output logic [7:0]                err_count
`endif
);

    localparam int              SW         = NUM_DIGITS + 7;
    localparam logic [7:0]      CNT_MAX    = 8'(STABLE_CYCLES);
    localparam logic [7:0]      CNT_COMMIT = 8'(STABLE_CYCLES - 2);
    localparam logic [6:0]      SEG_BLANK  = 7'h7F;

    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

    state_t                  state;
    logic [6:0]              seg_m, s_seg;
    logic [NUM_DIGITS-1:0]   an_m, s_an;
    logic [SW-1:0]           sample, prev;
    logic [7:0]              cnt;
    logic [NUM_DIGITS-1:0]   seen, seen_next, an_low;
    logic                    changed, an_idle, single, commit;
    logic [4:0]              seg_dec;
    logic                    seg_legal, seg_blank, seg_illegal;

    // Returns {legal, nibble}; the blank pattern is handled separately.
    function automatic logic [4:0] decode(input logic [6:0] p);
        logic [4:0] r;
        case (p)
            7'h40:   r = 5'h10;
            7'h79:   r = 5'h11;
            7'h24:   r = 5'h12;
            7'h30:   r = 5'h13;
            7'h19:   r = 5'h14;
            7'h12:   r = 5'h15;
            7'h02:   r = 5'h16;
            7'h78:   r = 5'h17;
            7'h00:   r = 5'h18;
            7'h10:   r = 5'h19;
            7'h08:   r = 5'h1A;
            7'h03:   r = 5'h1B;
            7'h46:   r = 5'h1C;
            7'h21:   r = 5'h1D;
            7'h06:   r = 5'h1E;
            7'h0E:   r = 5'h1F;
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_m <= '1;
            s_seg <= '1;
            an_m  <= '1;
            s_an  <= '1;
        end else begin
            seg_m <= seg_in;
            s_seg <= seg_m;
            an_m  <= an_in;
            s_an  <= an_m;
        end
    end

    assign sample      = {s_an, s_seg};
    assign changed     = (sample != prev);
    assign an_idle     = &s_an;
    assign an_low      = ~s_an;
    assign single      = (an_low != '0) && ((an_low & (an_low - NUM_DIGITS'(1))) == '0);
    assign commit      = (state == SETTLE) && !changed && (cnt == CNT_COMMIT);
    assign seg_dec     = decode(s_seg);
    assign seg_legal   = seg_dec[4];
    assign seg_blank   = (s_seg == SEG_BLANK);
    assign seg_illegal = !seg_legal && !seg_blank;
    assign seen_next   = seen | an_low;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            prev        <= '1;
            cnt         <= '0;
            seen        <= '0;
            digit_val   <= '0;
            digit_valid <= '0;
            digit_err   <= '0;
            an_conflict <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            prev       <= sample;
            frame_done <= 1'b0;

            if (changed)
                cnt <= '0;
            else if (cnt != CNT_MAX)
                cnt <= cnt + 8'd1;

            case (state)
                IDLE:    if (changed && !an_idle) state <= SETTLE;
                SETTLE: begin
                    if (changed) begin
                        if (an_idle) state <= IDLE;
                    end else if (cnt == CNT_COMMIT) begin
                        state <= HOLD;
                    end
                end
                HOLD:    if (changed) state <= an_idle ? IDLE : SETTLE;
                default: state <= IDLE;
            endcase

            if (commit) begin
                if (single) begin
                    for (int i = 0; i < NUM_DIGITS; i++) begin
                        if (an_low[i]) begin
                            if (seg_legal) begin
                                digit_val[4*i +: 4] <= seg_dec[3:0];
                                digit_valid[i]      <= 1'b1;
                                digit_err[i]        <= 1'b0;
                            end else begin
                                digit_valid[i]      <= 1'b0;
                                digit_err[i]        <= seg_illegal;
                            end
                        end
                    end
                    // Frame completes on this commit: pulse and restart tracking together.
                    if (&seen_next) begin
                        frame_done <= 1'b1;
                        seen       <= '0;
                    end else begin
                        seen       <= seen_next;
                    end
                end else begin
                    an_conflict <= 1'b1;
                end
            end
        end
    end

`ifdef SEVEN_ERR_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_count <= '0;
        else if (commit && (!single || seg_illegal) && (err_count != 8'hFF))
            err_count <= err_count + 8'd1;
    end
`endif

endmodule

// File: tb/tb_seven_scan_decoder.sv
// Bench for seven_scan_decoder (NUM_DIGITS=4, STABLE_CYCLES=4); err_count checks follow SEVEN_ERR_COUNT_EN.
module tb_seven_scan_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  seg_in = 7'h7F;
    logic [3:0]  an_in = 4'hF;
    logic [15:0] digit_val;
    logic [3:0]  digit_valid, digit_err;
    logic        an_conflict, frame_done;
`ifdef SEVEN_ERR_COUNT_EN
    logic [7:0]  err_count;
`endif

    int errors = 0;
    int checks = 0;
    int frame_cnt = 0;

    seven_scan_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_in      (seg_in),
        .an_in       (an_in),
        .digit_val   (digit_val),
        .digit_valid (digit_valid),
        .digit_err   (digit_err),
        .an_conflict (an_conflict),
        .frame_done  (frame_done)
`ifdef SEVEN_ERR_COUNT_EN
        ,
        .err_count   (err_count)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (rst_n && frame_done === 1'b1) frame_cnt++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        int         dig;
        logic [3:0] nib;
        logic       v;
        logic       e;
    } vec_t;

    vec_t tbl[20];
    vec_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n  = 1'b0;
        an_in  = 4'hF;
        seg_in = 7'h7F;
        frame_cnt = 0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();
    endtask

    task automatic hold(input logic [3:0] an, input logic [6:0] seg, input int n);
        an_in  = an;
        seg_in = seg;
        repeat (n) tick();
    endtask

    initial begin
        vec_t e;
        logic shown1;

        tbl[0]  = '{4'b1110, 7'h40, 0, 4'h0, 1'b1, 1'b0};
        tbl[1]  = '{4'b1101, 7'h79, 1, 4'h1, 1'b1, 1'b0};
        tbl[2]  = '{4'b1011, 7'h24, 2, 4'h2, 1'b1, 1'b0};
        tbl[3]  = '{4'b0111, 7'h30, 3, 4'h3, 1'b1, 1'b0};
        tbl[4]  = '{4'b1110, 7'h19, 0, 4'h4, 1'b1, 1'b0};
        tbl[5]  = '{4'b1101, 7'h12, 1, 4'h5, 1'b1, 1'b0};
        tbl[6]  = '{4'b1011, 7'h02, 2, 4'h6, 1'b1, 1'b0};
        tbl[7]  = '{4'b0111, 7'h78, 3, 4'h7, 1'b1, 1'b0};
        tbl[8]  = '{4'b1110, 7'h00, 0, 4'h8, 1'b1, 1'b0};
        tbl[9]  = '{4'b1101, 7'h10, 1, 4'h9, 1'b1, 1'b0};
        tbl[10] = '{4'b1011, 7'h08, 2, 4'hA, 1'b1, 1'b0};
        tbl[11] = '{4'b0111, 7'h03, 3, 4'hB, 1'b1, 1'b0};
        tbl[12] = '{4'b1110, 7'h46, 0, 4'hC, 1'b1, 1'b0};
        tbl[13] = '{4'b1101, 7'h21, 1, 4'hD, 1'b1, 1'b0};
        tbl[14] = '{4'b1011, 7'h06, 2, 4'hE, 1'b1, 1'b0};
        tbl[15] = '{4'b0111, 7'h0E, 3, 4'hF, 1'b1, 1'b0};
        tbl[16] = '{4'b1110, 7'h7F, 0, 4'hC, 1'b0, 1'b0};
        tbl[17] = '{4'b1101, 7'h55, 1, 4'hD, 1'b0, 1'b1};
        tbl[18] = '{4'b1011, 7'h01, 2, 4'hE, 1'b0, 1'b1};
        tbl[19] = '{4'b0111, 7'h40, 3, 4'h0, 1'b1, 1'b0};

        do_reset();
        check("reset digit_val", 32'(digit_val), 32'h0);
        check("reset digit_valid", 32'(digit_valid), 32'h0);
        check("reset an_conflict", 32'(an_conflict), 32'h0);

        // Full decode table across all digits, including blank and illegal patterns.
        for (int i = 0; i < 20; i++) begin
            an_in  = tbl[i].an;
            seg_in = tbl[i].seg;
            sb.push_back(tbl[i]);
            repeat (8) tick();
            e = sb.pop_front();
            check($sformatf("tbl%0d val", i), 32'(digit_val[4*e.dig +: 4]), 32'(e.nib));
            check($sformatf("tbl%0d valid", i), 32'(digit_valid[e.dig]), 32'(e.v));
            check($sformatf("tbl%0d err", i), 32'(digit_err[e.dig]), 32'(e.e));
        end
        check("tbl frame count", 32'(frame_cnt), 32'd5);
`ifdef SEVEN_ERR_COUNT_EN
        check("tbl err_count", 32'(err_count), 32'd2);
`endif

        // Asynchronous reset in the middle of a settle window.
        an_in  = 4'b1110;
        seg_in = 7'h12;
        repeat (3) tick();
        #1;
        rst_n = 1'b0;
        frame_cnt = 0;
        #1;
        check("async rst digit_val", 32'(digit_val), 32'h0);
        check("async rst valid", 32'(digit_valid), 32'h0);
        check("async rst err", 32'(digit_err), 32'h0);
        check("async rst frame_done", 32'(frame_done), 32'h0);
`ifdef SEVEN_ERR_COUNT_EN
        check("async rst err_count", 32'(err_count), 32'h0);
`endif
        @(posedge clk);
        #1;
        an_in  = 4'hF;
        seg_in = 7'h7F;
        rst_n  = 1'b1;
        repeat (10) tick();
        check("idle no frame", 32'(frame_cnt), 32'd0);
        check("idle valid", 32'(digit_valid), 32'h0);

        // Exact commit latency on digit 0.
        do_reset();
        an_in  = 4'b1110;
        seg_in = 7'h24;
        repeat (5) tick();
        check("lat5 valid", 32'(digit_valid), 32'h0);
        tick();
        check("lat6 valid", 32'(digit_valid), 32'b0001);
        check("lat6 val", 32'(digit_val[3:0]), 32'h2);
        repeat (4) tick();
        check("post hold val", 32'(digit_val), 32'h0002);
        check("post hold frame", 32'(frame_cnt), 32'd0);

        // A 3-cycle glitch must never commit.
        do_reset();
        shown1 = 1'b0;
        an_in  = 4'b1101;
        seg_in = 7'h79;
        repeat (3) begin
            tick();
            if (digit_valid[1] && digit_val[7:4] == 4'h1) shown1 = 1'b1;
        end
        seg_in = 7'h24;
        repeat (5) begin
            tick();
            if (digit_valid[1] && digit_val[7:4] == 4'h1) shown1 = 1'b1;
        end
        check("glitch lat5 valid", 32'(digit_valid[1]), 32'h0);
        tick();
        check("glitch never 1", 32'(shown1), 32'h0);
        check("glitch lat6 valid", 32'(digit_valid[1]), 32'h1);
        check("glitch lat6 val", 32'(digit_val[7:4]), 32'h2);

        // Full scan frame.
        do_reset();
        hold(4'b1110, 7'h79, 8);
        hold(4'b1101, 7'h24, 8);
        hold(4'b1011, 7'h08, 8);
        hold(4'b0111, 7'h0E, 8);
        check("scan val", 32'(digit_val), 32'hFA21);
        check("scan valid", 32'(digit_valid), 32'hF);
        check("scan frame count", 32'(frame_cnt), 32'd1);

        // Blank and illegal on digit 2, then conflicting anodes.
        do_reset();
        hold(4'b1011, 7'h24, 8);
        check("d2 legal valid", 32'(digit_valid), 32'b0100);
        hold(4'b1011, 7'h7F, 8);
        check("d2 blank valid", 32'(digit_valid), 32'h0);
        check("d2 blank err", 32'(digit_err), 32'h0);
        check("d2 blank val", 32'(digit_val), 32'h0200);
        hold(4'b1011, 7'h55, 8);
        check("d2 illegal err", 32'(digit_err), 32'b0100);
        check("d2 illegal val", 32'(digit_val), 32'h0200);
`ifdef SEVEN_ERR_COUNT_EN
        check("d2 illegal err_count", 32'(err_count), 32'd1);
`endif
        check("pre conflict", 32'(an_conflict), 32'h0);
        hold(4'b1100, 7'h24, 8);
        check("conflict flag", 32'(an_conflict), 32'h1);
        check("conflict val", 32'(digit_val), 32'h0200);
        check("conflict valid", 32'(digit_valid), 32'h0);
        check("conflict err", 32'(digit_err), 32'b0100);
`ifdef SEVEN_ERR_COUNT_EN
        check("conflict err_count", 32'(err_count), 32'd2);
`endif
        hold(4'hF, 7'h7F, 8);
        check("conflict sticky", 32'(an_conflict), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
